// File: rtl/dram_pkg.sv
// Shared command encoding, sequencer state type and default timing for the
// DRAM command sequencer and its per-bank timers.
package dram_pkg;

   typedef enum logic [1:0] {
      CMD_ACT = 2'b00,
      CMD_RD  = 2'b01,
      CMD_WR  = 2'b10,
      CMD_PRE = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_WAIT,
      ST_EXEC,
      ST_ACK
   } state_e;

   localparam int unsigned DEF_NUM_OF_BANKS = 8;
   localparam int unsigned DEF_NUM_OF_ROWS  = 128;
   localparam int unsigned DEF_NUM_OF_COLS  = 8;
   localparam int unsigned DEF_T_RCD        = 3;
   localparam int unsigned DEF_T_RAS        = 5;
   localparam int unsigned DEF_T_RP         = 3;
   localparam int unsigned DEF_T_CL         = 2;

   // Largest of the three bank timing values; sizes the shared counter width.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dram_bank_timer.sv
// Per-bank state: open flag, open row and the tRCD/tRAS/tRP down-counters.
// Counters run every cycle regardless of what the sequencer is doing.
module dram_bank_timer
   import dram_pkg::*;
#(
   parameter int unsigned ROW_W = 7,
   parameter int unsigned CNT_W = 3,
   parameter int unsigned T_RCD = DEF_T_RCD,
   parameter int unsigned T_RAS = DEF_T_RAS,
   parameter int unsigned T_RP  = DEF_T_RP
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             act_i,
   input  logic             pre_i,
   input  logic [ROW_W-1:0] row_i,
   output logic             open_o,
   output logic [ROW_W-1:0] open_row_o,
   output logic             rcd_zero_o,
   output logic             ras_zero_o,
   output logic             rp_zero_o
);

   logic             open_q;
   logic [ROW_W-1:0] open_row_q;
   logic [CNT_W-1:0] rcd_q, ras_q, rp_q;

   // Open-row tracking and saturating timing counters, reloaded on execute strobes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         open_q     <= 1'b0;
         open_row_q <= '0;
         rcd_q      <= '0;
         ras_q      <= '0;
         rp_q       <= '0;
      end else begin
         if (act_i) begin
            open_q     <= 1'b1;
            open_row_q <= row_i;
         end else if (pre_i) begin
            open_q <= 1'b0;
         end

         if (act_i)             rcd_q <= CNT_W'(T_RCD);
         else if (rcd_q != '0)  rcd_q <= rcd_q - CNT_W'(1);

         if (act_i)             ras_q <= CNT_W'(T_RAS);
         else if (ras_q != '0)  ras_q <= ras_q - CNT_W'(1);

         if (pre_i)             rp_q <= CNT_W'(T_RP);
         else if (rp_q != '0)   rp_q <= rp_q - CNT_W'(1);
      end
   end

   assign open_o     = open_q;
   assign open_row_o = open_row_q;
   assign rcd_zero_o = (rcd_q == '0);
   assign ras_zero_o = (ras_q == '0);
   assign rp_zero_o  = (rp_q == '0);

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Timing-correct DRAM command sequencer behind the cmd_req/cmd_ack handshake.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for cmd_req; latches command and encoded selects
// ST_DECODE | legality check against one-hot selects and bank open state
// ST_WAIT   | hold until the target bank's relevant counter reaches zero
// ST_EXEC   | array action: 1 cycle ACT/PRE, T_CL cycles READ/WRITE
// ST_ACK    | cmd_ack (and cmd_err) high until cmd_req drops
module dram_cmd_sequencer
   import dram_pkg::*;
#(
   parameter int unsigned NUM_OF_BANKS = DEF_NUM_OF_BANKS,
   parameter int unsigned NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
   parameter int unsigned NUM_OF_COLS  = DEF_NUM_OF_COLS,
   parameter int unsigned T_RCD        = DEF_T_RCD,
   parameter int unsigned T_RAS        = DEF_T_RAS,
   parameter int unsigned T_RP         = DEF_T_RP,
   parameter int unsigned T_CL         = DEF_T_CL
)(
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            cmd_req_i,
   input  logic [1:0]                      cmd_i,
   input  logic [NUM_OF_BANKS-1:0]         bank_sel_i,
   input  logic [NUM_OF_ROWS-1:0]          row_sel_i,
   input  logic [NUM_OF_COLS-1:0]          col_sel_i,
   output logic                            cmd_ack_o,
   output logic                            cmd_err_o,
   output logic [$clog2(NUM_OF_BANKS)-1:0] bank_id_o,
   output logic [$clog2(NUM_OF_ROWS)-1:0]  row_id_o,
   output logic [$clog2(NUM_OF_COLS)-1:0]  col_id_o,
   output logic                            bank_rw_o,
   output logic                            buffer_rw_o
);

   localparam int unsigned BW    = $clog2(NUM_OF_BANKS);
   localparam int unsigned RW    = $clog2(NUM_OF_ROWS);
   localparam int unsigned CW    = $clog2(NUM_OF_COLS);
   localparam int unsigned CNT_W = $clog2(max3(T_RCD, T_RAS, T_RP) + 1);
   localparam int unsigned CL_W  = $clog2(T_CL + 1);

   state_e            state_q, state_d;
   cmd_e              cmd_q;
   logic [BW-1:0]     bank_q, bank_enc;
   logic [RW-1:0]     row_q, row_enc, row_id_q;
   logic [CW-1:0]     col_q, col_enc;
   logic              bank_ok_q, row_ok_q, col_ok_q;
   logic [CL_W-1:0]   cl_cnt_q, cl_cnt_d;
   logic              ack_q, err_q, err_d, rw_q;
   logic              tgt_zero;

   logic [NUM_OF_BANKS-1:0] act_v, pre_v, open_v, rcd_zero_v, ras_zero_v, rp_zero_v;
   logic [RW-1:0]           open_row_v [NUM_OF_BANKS];

   for (genvar g = 0; g < NUM_OF_BANKS; g++) begin : g_bank
      dram_bank_timer #(
         .ROW_W (RW),
         .CNT_W (CNT_W),
         .T_RCD (T_RCD),
         .T_RAS (T_RAS),
         .T_RP  (T_RP)
      ) u_timer (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .act_i      (act_v[g]),
         .pre_i      (pre_v[g]),
         .row_i      (row_q),
         .open_o     (open_v[g]),
         .open_row_o (open_row_v[g]),
         .rcd_zero_o (rcd_zero_v[g]),
         .ras_zero_o (ras_zero_v[g]),
         .rp_zero_o  (rp_zero_v[g])
      );
   end

   // Select encoders; legality of the one-hot form is checked separately.
   always_comb begin
      bank_enc = '0;
      row_enc  = '0;
      col_enc  = '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) if (bank_sel_i[i]) bank_enc = BW'(i);
      for (int i = 0; i < NUM_OF_ROWS; i++)  if (row_sel_i[i])  row_enc  = RW'(i);
      for (int i = 0; i < NUM_OF_COLS; i++)  if (col_sel_i[i])  col_enc  = CW'(i);
   end

   // Execute strobes to the addressed bank timer.
   always_comb begin
      act_v = '0;
      pre_v = '0;
      if (state_q == ST_EXEC) begin
         for (int i = 0; i < NUM_OF_BANKS; i++) begin
            if (bank_q == BW'(i)) begin
               act_v[i] = (cmd_q == CMD_ACT);
               pre_v[i] = (cmd_q == CMD_PRE);
            end
         end
      end
   end

   // Counter that gates the target bank for the latched command.
   always_comb begin
      tgt_zero = 1'b0;
      case (cmd_q)
         CMD_ACT:        tgt_zero = rp_zero_v[bank_q];
         CMD_RD, CMD_WR: tgt_zero = rcd_zero_v[bank_q];
         CMD_PRE:        tgt_zero = ras_zero_v[bank_q];
         default:        tgt_zero = 1'b0;
      endcase
   end

   // Next-state logic for the handshake/command FSM.
   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      cl_cnt_d = cl_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_req_i) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            err_d   = 1'b0;
            state_d = ST_WAIT;
            if (!bank_ok_q) begin
               err_d   = 1'b1;
               state_d = ST_ACK;
            end else begin
               case (cmd_q)
                  CMD_ACT: begin
                     if (!row_ok_q || open_v[bank_q]) begin
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                     end
                  end
                  CMD_RD, CMD_WR: begin
                     if (!col_ok_q || !open_v[bank_q]) begin
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                     end
                  end
                  default: begin
                     // precharge of a closed bank is a harmless no-op
                     if (!open_v[bank_q]) state_d = ST_ACK;
                  end
               endcase
            end
         end
         ST_WAIT: begin
            if (tgt_zero) begin
               state_d  = ST_EXEC;
               cl_cnt_d = CL_W'(T_CL - 1);
            end
         end
         ST_EXEC: begin
            if ((cmd_q == CMD_RD || cmd_q == CMD_WR) && cl_cnt_q != '0) begin
               cl_cnt_d = cl_cnt_q - CL_W'(1);
            end else begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!cmd_req_i) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, command latch and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cmd_q     <= CMD_ACT;
         bank_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         bank_ok_q <= 1'b0;
         row_ok_q  <= 1'b0;
         col_ok_q  <= 1'b0;
         cl_cnt_q  <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rw_q      <= 1'b0;
         row_id_q  <= '0;
      end else begin
         state_q  <= state_d;
         cl_cnt_q <= cl_cnt_d;
         err_q    <= err_d;
         ack_q    <= (state_d == ST_ACK);
         rw_q     <= (state_d == ST_EXEC) && (cmd_q == CMD_WR);
         if (state_q == ST_IDLE) begin
            if (cmd_req_i) begin
               cmd_q     <= cmd_e'(cmd_i);
               bank_q    <= bank_enc;
               row_q     <= row_enc;
               col_q     <= col_enc;
               bank_ok_q <= $onehot(bank_sel_i);
               row_ok_q  <= $onehot(row_sel_i);
               col_ok_q  <= $onehot(col_sel_i);
               row_id_q  <= open_row_v[bank_enc];
            end
         end else if (state_q == ST_EXEC && cmd_q == CMD_ACT) begin
            // timer row updates on this same edge; forward it so ACK shows it
            row_id_q <= row_q;
         end else begin
            row_id_q <= open_row_v[bank_q];
         end
      end
   end

   assign cmd_ack_o   = ack_q;
   assign cmd_err_o   = err_q;
   assign bank_id_o   = bank_q;
   assign row_id_o    = row_id_q;
   assign col_id_o    = col_q;
   assign bank_rw_o   = rw_q;
   assign buffer_rw_o = rw_q;

endmodule

// File: doc/dram_cmd_sequencer.md
# dram_cmd_sequencer

Downstream of `dram_ctrl`: accepts its four-phase `cmd_req`/`cmd_ack` command handshake (one-hot bank/row/col selects), tracks open rows per bank, enforces activate/precharge/column timing, and drives the encoded address and `bank_rw`/`buffer_rw` strobes into the DRAM bank array. It replaces the fixed-delay handshake model with a timing-correct sequencer.

## Interface
- `NUM_OF_BANKS`, 8, banks; `bank_sel` width
- `NUM_OF_ROWS`, 128, rows per bank; `row_sel` width
- `NUM_OF_COLS`, 8, columns per row; `col_sel` width
- `T_RCD`, 3, cycles from ACTIVATE execute to first READ/WRITE on that bank
- `T_RAS`, 5, cycles from ACTIVATE execute to PRECHARGE allowed
- `T_RP`, 3, cycles from PRECHARGE execute to next ACTIVATE allowed
- `T_CL`, 2, EXEC length of READ/WRITE in cycles (≥1)
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `cmd_req` in 1 — request, held high until `cmd_ack` seen
- `cmd` in 2 — 00 ACTIVATE, 01 READ, 10 WRITE, 11 PRECHARGE
- `bank_sel` in NUM_OF_BANKS — one-hot bank
- `row_sel` in NUM_OF_ROWS — one-hot row (ACTIVATE only)
- `col_sel` in NUM_OF_COLS — one-hot column (READ/WRITE only)
- `cmd_ack` out 1 — handshake acknowledge
- `cmd_err` out 1 — valid with `cmd_ack`; command rejected, no array action
- `bank_id` out clog2(NUM_OF_BANKS) — encoded bank to array
- `row_id` out clog2(NUM_OF_ROWS) — open row of `bank_id`
- `col_id` out clog2(NUM_OF_COLS) — encoded column
- `bank_rw` out 1 — 1 write buffer→array, 0 read
- `buffer_rw` out 1 — 1 buffer takes data from bus (write), 0 buffer drives bus (read)

## Operation
- FSM: IDLE → DECODE → WAIT → EXEC → ACK → IDLE.
- IDLE: `cmd_req`=1 latches `cmd` and encoded selects; → DECODE.
- DECODE (1 cycle): reject (→ ACK, `cmd_err`=1) if `bank_sel` not exactly one-hot; ACTIVATE with bad `row_sel` or bank already open; READ/WRITE with bad `col_sel` or bank closed. PRECHARGE of closed bank: accepted, no-op, → ACK, `cmd_err`=0. Otherwise → WAIT.
- WAIT: stay while the bank's relevant counter ≠0 (ACTIVATE: rp_cnt; READ/WRITE: rcd_cnt; PRECHARGE: ras_cnt). Zero counter → EXEC next cycle (WAIT may take 1 cycle).
- EXEC: ACTIVATE 1 cycle: set open[bank], open_row[bank]=row, rcd_cnt=T_RCD, ras_cnt=T_RAS. PRECHARGE 1 cycle: clear open, rp_cnt=T_RP. READ/WRITE T_CL cycles, `bank_rw`=`buffer_rw`=(cmd==WRITE).
- ACK: `cmd_ack`=1 (and `cmd_err`) held until `cmd_req`=0 sampled, then `cmd_ack`=0, → IDLE.
- Per-bank counters decrement every cycle while nonzero, all banks in parallel, saturating at 0; counters of other banks run during any state.
- `bank_id`/`col_id`/`row_id` registered, held from DECODE until next IDLE latch; `row_id` = open_row of target bank.

## Timing
- Reset values: `cmd_ack`=0, `cmd_err`=0, `bank_rw`=0, `buffer_rw`=0, ids=0; all banks closed; all counters 0; FSM IDLE.
- `cmd_req` sampled at cycle 0 with counters zero: ACTIVATE/PRECHARGE `cmd_ack` high at cycle 4; READ/WRITE at cycle 3+T_CL; reject at cycle 2.
- `cmd_ack` falls the cycle after `cmd_req`=0 sampled; a new req is not sampled in the same cycle `cmd_ack` falls.
- `bank_rw`/`buffer_rw` are 0 outside READ/WRITE EXEC.
- Reset mid-command: all state cleared next edge; a still-high `cmd_req` after reset is treated as a new request.
- Counter width clog2(max(T_RCD,T_RAS,T_RP)+1).

## Structure
- `dram_pkg`: cmd encoding constants, FSM state typedef, default timing values.
- One sub-module `dram_bank_timer` (instantiated NUM_OF_BANKS times): open flag, open row, rcd/ras/rp counters, load on activate/precharge strobes.
- Top holds FSM, one-hot checks/encoders, output registers.

## Test plan
- Reset, ACTIVATE bank_sel=8'h04 row_sel bit 17 → `cmd_ack` at cycle 4, `cmd_err`=0, bank_id=2, row_id=17.
- Then immediate WRITE bank 2 col_sel=8'h08 → WAIT until rcd_cnt=0; `bank_rw`=`buffer_rw`=1 for 2 cycles, col_id=3, row_id=17.
- READ to closed bank 5 → ack at cycle 2, `cmd_err`=1, `bank_rw`/`buffer_rw` stay 0.
- PRECHARGE bank 2 one cycle after ACTIVATE → EXEC delayed until T_RAS=5 expired; following ACTIVATE bank 2 waits T_RP=3.
- bank_sel=8'h00 and 8'h03 → `cmd_err`=1, no state change; ACTIVATE on open bank → `cmd_err`=1.
- Assert `rst` during READ EXEC → outputs to reset values next cycle; subsequent READ same bank → `cmd_err`=1 (bank closed).
